// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares a single FIFO write port among four
// requesters. A grant lasts until its owner drops its request or has had
// MAX_BURST words written. The FIFO full flag stalls the grant without
// any timeout.
module fifo_write_arbiter #(
    parameter int WORD_SIZE  = 4,
    parameter int REQUESTERS = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [REQUESTERS-1:0]           request,
    input  logic [REQUESTERS*WORD_SIZE-1:0] data_in,
    input  logic                            fifo_full,
    output logic [REQUESTERS-1:0]           grant,
    output logic [REQUESTERS-1:0]           accept,
    output logic                            fifo_write_enable,
    output logic [WORD_SIZE-1:0]            fifo_data,
    output logic                            busy
);

    // The burst counter is 4 bits wide, so MAX_BURST is limited to 1..15.
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [REQUESTERS-1:0]   grant_q, grant_d;
    logic [1:0]              owner_q, owner_d;
    logic [1:0]              last_q, last_d;
    logic [3:0]              burst_q, burst_d;

    logic [1:0]              pick_idx;
    logic                    pick_found;
    logic [1:0]              cand_idx;
    logic                    owner_req;
    logic [3:0]              burst_inc;
    logic [WORD_SIZE-1:0]    data_words [REQUESTERS];

    // Split the packed data bus into one word per requester, and gate each
    // accept bit with the shared write strobe.
    genvar gi;
    generate
        for (gi = 0; gi < REQUESTERS; gi++) begin : g_slice
            assign data_words[gi] = data_in[gi*WORD_SIZE +: WORD_SIZE];
            assign accept[gi]     = grant_q[gi] & fifo_write_enable;
        end
    endgenerate

    assign busy              = (state_q == GRANT);
    assign owner_req         = request[owner_q];
    assign fifo_write_enable = busy & owner_req & ~fifo_full;
    assign fifo_data         = busy ? data_words[owner_q] : '0;
    assign grant             = grant_q;
    assign burst_inc         = burst_q + 4'd1;

    // Round-robin search: first requesting index starting after the last owner.
    always_comb begin
        pick_idx   = last_q + 2'd1;
        pick_found = 1'b0;
        cand_idx   = 2'd0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            cand_idx = last_q + 2'(k);
            if (!pick_found && request[cand_idx]) begin
                pick_idx   = cand_idx;
                pick_found = 1'b1;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE; in GRANT count words and decide release.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << pick_idx;
                    owner_d = pick_idx;
                    burst_d = 4'd0;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    // Owner withdrew; this also applies while the FIFO is full.
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else if (fifo_write_enable) begin
                    burst_d = burst_inc;
                    if (burst_inc == BURST_LIMIT) begin
                        state_d = IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                    end
                end
                // FIFO full with owner still requesting: hold everything.
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset aborts any grant at once and gives requester 0 priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            burst_q <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: round-robin bursts, single grant,
// FIFO-full stall, early release, and reset in the middle of a burst.
module tb_fifo_write_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  request;
    logic [15:0] data_in;
    logic        fifo_full;
    logic [3:0]  grant;
    logic [3:0]  accept;
    logic        fifo_write_enable;
    logic [3:0]  fifo_data;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    fifo_write_arbiter #(
        .WORD_SIZE (4),
        .REQUESTERS(4),
        .MAX_BURST (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .request          (request),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .grant            (grant),
        .accept           (accept),
        .fifo_write_enable(fifo_write_enable),
        .fifo_data        (fifo_data),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Words per requester: slice0=1, slice1=2, slice2=A, slice3=4.
    function automatic logic [3:0] word_of(input int idx);
        case (idx)
            0:       return 4'h1;
            1:       return 4'h2;
            2:       return 4'hA;
            default: return 4'h4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic we,
                           input logic [3:0] d);
        chk({tag, ".grant"},  32'(grant), 32'(g));
        chk({tag, ".busy"},   32'(busy), 32'(g != 4'b0000));
        chk({tag, ".we"},     32'(fifo_write_enable), 32'(we));
        chk({tag, ".accept"}, 32'(accept), 32'(we ? g : 4'b0000));
        chk({tag, ".data"},   32'(fifo_data), 32'(d));
    endtask

    // Check one cycle's outputs shortly after inputs settle, then advance a cycle.
    task automatic cyc(input string tag, input logic [3:0] g, input logic we,
                       input logic [3:0] d);
        #1;
        chk_all(tag, g, we, d);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        request   = 4'b1111;
        data_in   = 16'h4A21;
        fifo_full = 1'b0;

        // Reset holds every output low even with all requests active.
        @(posedge clock);
        #1;
        cyc("reset", 4'b0000, 1'b0, 4'h0);
        reset = 1'b0;

        // Round robin 0,1,2,3,0: four writes each, one idle cycle between.
        cyc("rr_idle_first", 4'b0000, 1'b0, 4'h0);
        for (int g = 0; g < 5; g++) begin
            for (int w = 0; w < 4; w++)
                cyc($sformatf("rr_g%0d_w%0d", g, w), 4'b0001 << (g % 4), 1'b1, word_of(g % 4));
            if (g == 4) request = 4'b0100;
            cyc($sformatf("rr_idle_%0d", g), 4'b0000, 1'b0, 4'h0);
        end

        // Single requester 2 granted one cycle after request.
        cyc("single_grant", 4'b0100, 1'b1, 4'hA);
        request = 4'b0000;
        cyc("single_drop", 4'b0100, 1'b0, 4'hA);

        // Requester 1: two writes, five full cycles, two more writes, release.
        request = 4'b0010;
        cyc("full_idle", 4'b0000, 1'b0, 4'h0);
        cyc("full_w0", 4'b0010, 1'b1, 4'h2);
        cyc("full_w1", 4'b0010, 1'b1, 4'h2);
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++)
            cyc($sformatf("full_stall%0d", s), 4'b0010, 1'b0, 4'h2);
        fifo_full = 1'b0;
        cyc("full_w2", 4'b0010, 1'b1, 4'h2);
        cyc("full_w3", 4'b0010, 1'b1, 4'h2);
        request = 4'b0000;
        cyc("full_release", 4'b0000, 1'b0, 4'h0);

        // Requester 3 drops after one write while requester 0 waits.
        request = 4'b1000;
        cyc("drop_idle", 4'b0000, 1'b0, 4'h0);
        cyc("drop_w0", 4'b1000, 1'b1, 4'h4);
        request = 4'b0001;
        cyc("drop_rel", 4'b1000, 1'b0, 4'h4);
        cyc("drop_gap", 4'b0000, 1'b0, 4'h0);
        cyc("drop_next", 4'b0001, 1'b1, 4'h1);
        request = 4'b0000;
        cyc("drop_next_rel", 4'b0001, 1'b0, 4'h1);

        // Reset during a write cycle of requester 2, then requester 0 first.
        request = 4'b0100;
        cyc("rst_idle", 4'b0000, 1'b0, 4'h0);
        cyc("rst_w0", 4'b0100, 1'b1, 4'hA);
        #1;
        chk("rst_pre_we", 32'(fifo_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        chk_all("rst_async", 4'b0000, 1'b0, 4'h0);
        @(posedge clock);
        #1;
        chk_all("rst_held", 4'b0000, 1'b0, 4'h0);
        reset   = 1'b0;
        request = 4'b0101;
        cyc("post_rst_idle", 4'b0000, 1'b0, 4'h0);
        for (int w = 0; w < 4; w++)
            cyc($sformatf("post_rst_w%0d", w), 4'b0001, 1'b1, 4'h1);
        request = 4'b0000;
        cyc("post_rst_release", 4'b0000, 1'b0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
